// File: rtl/systolic_mm_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic matrix-multiply job controller:
//   - state_t          : controller state encoding
//   - SYS_N / SYS_W    : default array dimension and element width
//   - FEED_CYCLES      : length of the skewed operand feed (2N-1)
//   - DRAIN_CYCLES     : cycles for the last products to reach the far PE (N-1)
//   - CNT_W            : width of the step counter, clog2(2N)
//   - elem_lsb()       : bit offset of element (row,col) in a row-major flat
//                        matrix; the array wrapper uses the same packing
// ---------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int SYS_N = 3;
    localparam int SYS_W = 8;

    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_cycles(input int n);
        return n - 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

    localparam int FEED_CYCLES  = feed_cycles(SYS_N);
    localparam int DRAIN_CYCLES = drain_cycles(SYS_N);
    localparam int CNT_W        = cnt_w(SYS_N);

    function automatic int elem_lsb(input int row, input int col,
                                    input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// ---------------------------------------------------------------------------
// systolic_skew_mux
// Combinational diagonal skew of the latched operands for one feed step.
//   step     : feed step s (0 .. 2N-2)
//   a_mat    : latched matrix A, element (i,k) at [(i*N+k)*W +: W]
//   b_mat    : latched matrix B, element (k,j) at [(k*N+j)*W +: W]
//   row_next : row i gets A[i][s-i] when 0 <= s-i < N, else 0
//   col_next : column j gets B[s-j][j] when 0 <= s-j < N, else 0
// The parent registers both outputs.
// ---------------------------------------------------------------------------
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int N     = SYS_N,
    parameter int W     = SYS_W,
    parameter int STEPW = cnt_w(N)
) (
    input  logic [STEPW-1:0] step,
    input  logic [N*N*W-1:0] a_mat,
    input  logic [N*N*W-1:0] b_mat,
    output logic [N*W-1:0]   row_next,
    output logic [N*W-1:0]   col_next
);

    // Row i lags row i-1 by one step, so row i sees element k = s-i; the
    // same skew on columns lines A[i][k] and B[k][j] up at PE (i,j).
    always_comb begin
        row_next = '0;
        col_next = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(step) - i;
            if (k >= 0 && k < N) begin
                row_next[i*W +: W] = a_mat[elem_lsb(i, k, N, W) +: W];
                col_next[i*W +: W] = b_mat[elem_lsb(k, i, N, W) +: W];
            end
        end
    end

endmodule

// File: rtl/systolic_mm_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_mm_scheduler
// Job controller for an NxN systolic MAC array: latches one operand pair,
// clears the accumulators, streams skewed rows/columns, waits for the
// pipeline to drain, captures the product and holds it until acknowledged.
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : job request, operands sampled on the accepting edge
//   a_flat/b_flat : operand matrices, row-major flat packing
//   busy          : high from accept until the result is acknowledged
//   row_feed      : array row inputs, row i at [i*W +: W]
//   col_feed      : array column inputs, column j at [j*W +: W]
//   mac_clr       : synchronous accumulator clear to all PEs
//   c_flat        : PE accumulator outputs
//   result        : captured product C
//   result_valid  : result holds a completed job
//   result_ack    : consumer accepts result
// ---------------------------------------------------------------------------
module systolic_mm_scheduler
    import systolic_pkg::*;
#(
    parameter int N = SYS_N,
    parameter int W = SYS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] b_flat,
    output logic             busy,
    output logic [N*W-1:0]   row_feed,
    output logic [N*W-1:0]   col_feed,
    output logic             mac_clr,
    input  logic [N*N*W-1:0] c_flat,
    output logic [N*N*W-1:0] result,
    output logic             result_valid,
    input  logic             result_ack
);

    localparam int            CW         = cnt_w(N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(feed_cycles(N) - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(N) - 1);

    state_t             state;
    logic [CW-1:0]      step;
    logic [N*N*W-1:0]   a_reg;
    logic [N*N*W-1:0]   b_reg;
    logic [CW-1:0]      mux_step;
    logic [N*W-1:0]     row_next;
    logic [N*W-1:0]     col_next;

    // Feeds are registered, so the mux looks one step ahead: from CLEAR it
    // prepares step 0, from FEED it prepares the step about to be entered.
    assign mux_step = (state == CLEAR) ? '0 : step + CW'(1);

    systolic_skew_mux #(
        .N     (N),
        .W     (W),
        .STEPW (CW)
    ) u_skew (
        .step     (mux_step),
        .a_mat    (a_reg),
        .b_mat    (b_reg),
        .row_next (row_next),
        .col_next (col_next)
    );

    // Single controller process: every output is loaded on the edge that
    // enters the state it belongs to, so outputs line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            step         <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            busy         <= 1'b0;
            mac_clr      <= 1'b0;
            row_feed     <= '0;
            col_feed     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a_flat;
                        b_reg   <= b_flat;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    mac_clr  <= 1'b0;
                    step     <= '0;
                    row_feed <= row_next;
                    col_feed <= col_next;
                    state    <= FEED;
                end
                FEED: begin
                    if (step == FEED_LAST) begin
                        step     <= '0;
                        row_feed <= '0;
                        col_feed <= '0;
                        state    <= DRAIN;
                    end else begin
                        step     <= step + CW'(1);
                        row_feed <= row_next;
                        col_feed <= col_next;
                    end
                end
                DRAIN: begin
                    if (step == DRAIN_LAST) begin
                        step  <= '0;
                        state <= CAPTURE;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                CAPTURE: begin
                    result       <= c_flat;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    // A start arriving with the ack chains the next job
                    // straight into CLEAR without visiting IDLE.
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            a_reg   <= a_flat;
                            b_reg   <= b_flat;
                            mac_clr <= 1'b1;
                            state   <= CLEAR;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_systolic_mm_scheduler
// Bench for the systolic job controller. A small behavioural PE array
// closes the loop from the feeds back to c_flat; expected products come
// from a reference matmul function and are queued when a job is started.
// ---------------------------------------------------------------------------
module tb_systolic_mm_scheduler;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int MW = N * N * W;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [MW-1:0] a_flat;
    logic [MW-1:0] b_flat;
    logic          busy;
    logic [VW-1:0] row_feed;
    logic [VW-1:0] col_feed;
    logic          mac_clr;
    logic [MW-1:0] c_flat;
    logic [MW-1:0] result;
    logic          result_valid;
    logic          result_ack;

    int            errors    = 0;
    int            checks    = 0;
    int            cyc       = 0;
    int            start_cyc = 0;
    logic [MW-1:0] exp_q[$];

    systolic_mm_scheduler #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .busy         (busy),
        .row_feed     (row_feed),
        .col_feed     (col_feed),
        .mac_clr      (mac_clr),
        .c_flat       (c_flat),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    // Behavioural PE grid: A moves right, B moves down, one register per hop.
    logic [W-1:0] pa  [N][N];
    logic [W-1:0] pb  [N][N];
    logic [W-1:0] acc [N][N];
    logic [W-1:0] ain [N][N];
    logic [W-1:0] bin [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = row_feed[i*W +: W];
            bin[0][i] = col_feed[i*W +: W];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = pa[i][j-1];
                bin[j][i] = pb[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa[i][j]  <= ain[i][j];
                pb[i][j]  <= bin[i][j];
                acc[i][j] <= mac_clr ? '0 : acc[i][j] + ain[i][j] * bin[i][j];
            end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_flat[(i*N+j)*W +: W] = acc[i][j];
    end

    function automatic logic [W-1:0] elem(input logic [MW-1:0] m, input int r, input int c);
        return m[(r*N+c)*W +: W];
    endfunction

    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [W-1:0] sum;
                sum = '0;
                for (int k = 0; k < N; k++) begin
                    logic [W-1:0] prod;
                    prod = elem(a, i, k) * elem(b, k, j);
                    sum = sum + prod;
                end
                m[(i*N+j)*W +: W] = sum;
            end
        end
        return m;
    endfunction

    function automatic logic [VW-1:0] skew_row(input logic [MW-1:0] a, input int s);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (s - i >= 0 && s - i < N)
                v[i*W +: W] = elem(a, i, s - i);
        return v;
    endfunction

    function automatic logic [VW-1:0] skew_col(input logic [MW-1:0] b, input int s);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (s - j >= 0 && s - j < N)
                v[j*W +: W] = elem(b, s - j, j);
        return v;
    endfunction

    function automatic logic [MW-1:0] diag(input logic [W-1:0] v);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            m[(i*N+i)*W +: W] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++)
            m[e*W +: W] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] seq_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++)
            m[e*W +: W] = W'(e + 1);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++)
            m[e*W +: W] = W'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                               input logic [MW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive an accepted start for one edge and queue its expected product.
    task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        exp_q.push_back(matmul(a, b));
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic awaitResult(input string tag);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (result_valid !== 1'b1) begin
            checkOutput({tag, "_timeout"}, MW'(result_valid), MW'(1));
        end else begin
            checkOutput({tag, "_latency"}, MW'(cyc - start_cyc), MW'(3 * N + 1));
            if (exp_q.size() == 0)
                checkOutput({tag, "_sb_empty"}, MW'(0), MW'(1));
            else
                checkOutput({tag, "_result"}, result, exp_q.pop_front());
        end
    endtask

    task automatic ackResult(input string tag);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checkOutput({tag, "_valid_after_ack"}, MW'(result_valid), MW'(0));
        checkOutput({tag, "_busy_after_ack"}, MW'(busy), MW'(0));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, MW'(busy), MW'(0));
        checkOutput({tag, "_mac_clr"}, MW'(mac_clr), MW'(0));
        checkOutput({tag, "_row"}, MW'(row_feed), MW'(0));
        checkOutput({tag, "_col"}, MW'(col_feed), MW'(0));
        checkOutput({tag, "_result"}, result, MW'(0));
        checkOutput({tag, "_valid"}, MW'(result_valid), MW'(0));
    endtask

    initial begin
        logic [MW-1:0] a1;
        logic [MW-1:0] b1;

        rst_n      = 1'b0;
        start      = 1'b0;
        result_ack = 1'b0;
        a_flat     = '0;
        b_flat     = '0;
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        checkIdleOutputs("reset");

        // Identity x B with a full feed trace.
        a1 = diag(8'h01);
        b1 = seq_mat();
        applyStimulus(a1, b1);
        checkOutput("id_clr_c1", MW'(mac_clr), MW'(1));
        checkOutput("id_busy_c1", MW'(busy), MW'(1));
        checkOutput("id_row_c1", MW'(row_feed), MW'(0));
        for (int s = 0; s < 2*N-1; s++) begin
            tick();
            checkOutput($sformatf("id_row_s%0d", s), MW'(row_feed), MW'(skew_row(a1, s)));
            checkOutput($sformatf("id_col_s%0d", s), MW'(col_feed), MW'(skew_col(b1, s)));
            checkOutput($sformatf("id_clr_s%0d", s), MW'(mac_clr), MW'(0));
        end
        tick();
        checkOutput("id_drain_row", MW'(row_feed), MW'(0));
        checkOutput("id_drain_clr", MW'(mac_clr), MW'(0));
        awaitResult("identity");
        checkOutput("id_is_b", result, b1);
        ackResult("identity");
        checkOutput("id_result_held", result, b1);

        // All ones.
        applyStimulus(fill(8'h01), fill(8'h01));
        awaitResult("ones");
        checkOutput("ones_elem", result, fill(8'h03));
        ackResult("ones");

        // Wrap: 0xFF*0xFF keeps only the low byte.
        applyStimulus(fill(8'hFF), fill(8'hFF));
        awaitResult("wrap");
        checkOutput("wrap_elem", result, fill(8'h03));
        ackResult("wrap");

        // Starts pulsed mid-job are ignored and operands stay latched.
        a1 = rand_mat();
        b1 = rand_mat();
        applyStimulus(a1, b1);
        tick();
        tick();
        a_flat = rand_mat();
        b_flat = rand_mat();
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 2; s < 2*N-1; s++) begin
            checkOutput($sformatf("ign_row_s%0d", s), MW'(row_feed), MW'(skew_row(a1, s)));
            checkOutput($sformatf("ign_col_s%0d", s), MW'(col_feed), MW'(skew_col(b1, s)));
            tick();
        end
        a_flat = rand_mat();
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ign_busy", MW'(busy), MW'(1));
        awaitResult("ignore");

        // Start without ack in DONE does nothing.
        a_flat = diag(8'h05);
        start  = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("done_hold_valid", MW'(result_valid), MW'(1));
        checkOutput("done_hold_result", result, matmul(a1, b1));

        // Back-to-back: ack and start together go straight to CLEAR.
        result_ack = 1'b1;
        applyStimulus(diag(8'h02), diag(8'h01));
        result_ack = 1'b0;
        checkOutput("b2b_clr", MW'(mac_clr), MW'(1));
        checkOutput("b2b_busy", MW'(busy), MW'(1));
        checkOutput("b2b_valid", MW'(result_valid), MW'(0));
        awaitResult("b2b");
        checkOutput("b2b_diag", result, diag(8'h02));

        // Reset in the middle of FEED step 2, then a fresh job.
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        applyStimulus(rand_mat(), rand_mat());
        tick();
        tick();
        tick();
        checkOutput("pre_rst_busy", MW'(busy), MW'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checkIdleOutputs("midrst");
        applyStimulus(rand_mat(), rand_mat());
        awaitResult("post_rst");
        ackResult("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_mm_scheduler.md
Name: systolic_mm_scheduler

Overview:
- Job controller for the 3x3 weight-free systolic matrix-multiply array (grid of MAC PEs, A streamed along rows, B along columns).
- Accepts one pair of N×N operand matrices per job, clears the PE accumulators, and drives the diagonally skewed row/column feeds each cycle.
- Waits for the pipeline to drain, captures the N×N result, and holds it under a valid/ack handshake.
- Replaces free-running, reset-less feed sequencing with a restartable, handshaked controller.

Parameters:
- N, 3, matrix dimension (array is N×N PEs).
- W, 8, element width in bits for operands and results.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a job; operands sampled on the accepting edge.
- a_flat  in  N*N*W  matrix A, element (i,k) at bits [(i*N+k)*W +: W].
- b_flat  in  N*N*W  matrix B, element (k,j) at bits [(k*N+j)*W +: W].
- busy  out  1  high from accept until the result is acknowledged.
- row_feed  out  N*W  array row inputs, row i at [i*W +: W].
- col_feed  out  N*W  array column inputs, column j at [j*W +: W].
- mac_clr  out  1  synchronous accumulator clear to all PEs.
- c_flat  in  N*N*W  PE accumulator outputs, (i,j) at [(i*N+j)*W +: W].
- result  out  N*N*W  captured product C, same packing as c_flat.
- result_valid  out  1  result holds a completed job.
- result_ack  in  1  consumer accepts result.

Behaviour:
- Array contract:
  - PE operand pass-through is registered (1 cycle per hop).
  - Accumulator is registered, output = accumulator, clear on mac_clr at clock edge.
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, mac_clr=0, row_feed=col_feed=0, result=0, result_valid=0, step counter=0, operand registers=0. Reset overrides any state, including mid-FEED.
- States: IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE.
- IDLE: start=1 latches a_flat and b_flat into internal registers, then goes to CLEAR.
- CLEAR (1 cycle): mac_clr=1, feeds 0.
- FEED (2N-1 cycles, step s=0..2N-2):
  - row_feed[i] = A[i][s-i] if 0≤s-i<N, else 0.
  - col_feed[j] = B[s-j][j] if 0≤s-j<N, else 0.
- DRAIN (N-1 cycles): feeds 0.
- CAPTURE (1 cycle): result<=c_flat. Next state DONE.
- DONE: result_valid=1, result held stable.
  - result_ack=1 with start=0 goes to IDLE.
  - result_ack=1 with start=1 latches the new operands and goes straight to CLEAR (back-to-back job).
  - start without ack is ignored.
- Outputs are registered and decoded from the state and step registers: feeds, mac_clr, busy, result_valid.
- busy=1 in CLEAR..DONE.
- result_valid deasserts on the edge after ack. Outputs do not return to reset values.
- start is ignored in every state except IDLE and DONE(with ack); latched operands are never disturbed mid-job.
- Latency (start sampled in cycle 0):
  - CLEAR in cycle 1.
  - FEED in cycles 2..2N.
  - DRAIN in cycles 2N+1..3N-1.
  - CAPTURE in cycle 3N.
  - result_valid in cycle 3N+1 (N=3: FEED 2..6, valid at cycle 10).
- Arithmetic: the scheduler does no math. Results are the PEs' W-bit accumulators, wrap modulo 2^W, and are passed unchanged.
- Step counter width: clog2(2N).
- Counter reload:
  - resets to 0 on entering FEED and on entering DRAIN.
  - terminal counts are 2N-2 (FEED) and N-2 (DRAIN).
  - N=2 is the minimum legal value (DRAIN=1 cycle).

Decomposition:
- Package systolic_pkg:
  - state enum.
  - localparams FEED_CYCLES=2N-1, DRAIN_CYCLES=N-1, CNT_W.
  - element-slice index function shared with the array wrapper.
- One sub-module, systolic_skew_mux:
  - combinational.
  - maps step s plus the latched A/B to next row_feed/col_feed.
  - registered by the parent.

Test Plan:
- Identity × B: A=I, B=rows{1,2,3},{4,5,6},{7,8,9}, start one cycle → result_valid at cycle 10, result==B. Feed trace in cycles 2..6 matches the skew formula exactly, and mac_clr is high only in cycle 1.
- All-ones: A=B=all 8'h01 → every result element 8'h03. Apply ack → busy=0 next cycle.
- Wrap: A=B=all 8'hFF → each product wraps to 1 → every element 8'h03, no overflow flag.
- start pulsed in cycles 3 and 7 with different operands → ignored; result equals the first job, and the latched operands are unchanged.
- Back-to-back: in DONE, drive result_ack=1 and start=1 together with new A=2·I, B=I → CLEAR next cycle, no IDLE cycle, second result diag 8'h02, and the first job's residue is cleared.
- rst_n=0 for one edge during FEED step 2 → next cycle all outputs are at their reset values. A fresh start then completes correctly with normal latency.
